// File: rtl/awg_playout_pkg.sv
// rtl/awg_playout_pkg.sv - trigger mode codes and state encodings for the AWG playout block
package awg_playout_pkg;

    localparam logic [6:0] TRIGGER_MODE_NONE = 7'd0;
    localparam logic [6:0] TRIGGER_MODE_EDGE = 7'd1;
    localparam logic [6:0] RESET_EDGE        = 7'd2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        RUNNING = 2'd2
    } state_t;

    function automatic logic mode_is_valid(input logic [6:0] mode);
        return (mode == TRIGGER_MODE_NONE) || (mode == TRIGGER_MODE_EDGE) || (mode == RESET_EDGE);
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// rtl/sample_fifo.sv - synchronous sample FIFO with registered level, flush and fall-through read
module sample_fifo #(
    parameter int BW         = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk100,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [BW-1:0]         wr_data,
    output logic [BW-1:0]         rd_data,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  full
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [BW-1:0]         mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    // Both gates look only at the registered level, so a pop never sees a same-edge push.
    assign full    = (level == (DEPTH_LOG2+1)'(DEPTH));
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && (level != '0) && !flush;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk100 or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk100) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/awg_playout.sv
// rtl/awg_playout.sv - triggered sample playout to a DAC at a divided tick rate
module awg_playout
    import awg_playout_pkg::*;
#(
    parameter int BW_OUT     = 8,
    parameter int DEPTH_LOG2 = 4,
    parameter int DIV        = 4
) (
    input  logic                  clk100,
    input  logic                  rst,
    input  logic                  awg_valid,
    output logic                  awg_ready,
    input  logic [BW_OUT-1:0]     awg_out,
    input  logic [6:0]            trigger_mode,
    input  logic                  trig_in,
    output logic [BW_OUT-1:0]     dac_data,
    output logic                  dac_strobe,
    output logic [DEPTH_LOG2:0]   fifo_level,
    output logic                  armed,
    output logic                  underrun_latched
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] TICK_RELOAD = CW'(DIV - 1);

    state_t             state, state_next;
    logic [CW-1:0]      tick_cnt;
    logic               tick;
    logic               trig_s1, trig_s2, trig_s3;
    logic               trig_rise;
    logic [6:0]         mode_q;
    logic               played;
    logic               fifo_pop, fifo_flush, fifo_full, set_underrun;
    logic [BW_OUT-1:0]  fifo_rd_data;

    sample_fifo #(.BW(BW_OUT), .DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
        .clk100  (clk100),
        .rst     (rst),
        .push    (awg_valid),
        .pop     (fifo_pop),
        .flush   (fifo_flush),
        .wr_data (awg_out),
        .rd_data (fifo_rd_data),
        .level   (fifo_level),
        .full    (fifo_full)
    );

    assign awg_ready = !fifo_full;
    assign armed     = (state == ARMED);
    assign tick      = (tick_cnt == '0);
    assign trig_rise = trig_s2 && !trig_s3;

    always_ff @(posedge clk100 or posedge rst) begin
        if (rst) begin
            tick_cnt <= TICK_RELOAD;
            trig_s1  <= 1'b0;
            trig_s2  <= 1'b0;
            trig_s3  <= 1'b0;
            mode_q   <= TRIGGER_MODE_NONE;
        end else begin
            tick_cnt <= tick ? TICK_RELOAD : tick_cnt - 1'b1;
            trig_s1  <= trig_in;
            trig_s2  <= trig_s1;
            trig_s3  <= trig_s2;
            mode_q   <= trigger_mode;
        end
    end

    // Mode change beats everything, then an illegal mode, then a flush request.
    always_comb begin
        state_next   = state;
        fifo_pop     = 1'b0;
        fifo_flush   = 1'b0;
        set_underrun = 1'b0;
        if (trigger_mode != mode_q) begin
            state_next = IDLE;
        end else if (!mode_is_valid(trigger_mode)) begin
            state_next   = IDLE;
            set_underrun = 1'b1;
        end else if (trigger_mode == RESET_EDGE && trig_rise) begin
            fifo_flush = 1'b1;
            state_next = ARMED;
        end else begin
            case (state)
                IDLE:    state_next = (trigger_mode == TRIGGER_MODE_NONE) ? RUNNING : ARMED;
                ARMED:   if (trigger_mode == TRIGGER_MODE_EDGE && trig_rise) state_next = RUNNING;
                RUNNING: begin
                    if (tick) begin
                        if (fifo_level != '0) begin
                            fifo_pop = 1'b1;
                        end else if (played) begin
                            if (trigger_mode == TRIGGER_MODE_EDGE) state_next = ARMED;
                            else                                   set_underrun = 1'b1;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk100 or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            played           <= 1'b0;
            dac_data         <= '0;
            dac_strobe       <= 1'b0;
            underrun_latched <= 1'b0;
        end else begin
            state      <= state_next;
            dac_strobe <= fifo_pop;
            if (fifo_pop) dac_data <= fifo_rd_data;
            // Burst history restarts every time RUNNING is (re)entered.
            if (state != RUNNING) played <= 1'b0;
            else if (fifo_pop)    played <= 1'b1;
            if (set_underrun) underrun_latched <= 1'b1;
        end
    end

endmodule

// File: tb/tb_awg_playout.sv
// tb/tb_awg_playout.sv - directed self-checking bench for awg_playout
module tb_awg_playout;
    import awg_playout_pkg::*;

    logic       clk100 = 1'b0;
    logic       rst = 1'b1;
    logic       awg_valid = 1'b0;
    logic       awg_ready;
    logic [7:0] awg_out = 8'h00;
    logic [6:0] trigger_mode = 7'd0;
    logic       trig_in = 1'b0;
    logic [7:0] dac_data;
    logic       dac_strobe;
    logic [4:0] fifo_level;
    logic       armed;
    logic       underrun_latched;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    logic [7:0] sdata[$];
    int         stime[$];

    awg_playout #(.BW_OUT(8), .DEPTH_LOG2(4), .DIV(4)) dut (
        .clk100           (clk100),
        .rst              (rst),
        .awg_valid        (awg_valid),
        .awg_ready        (awg_ready),
        .awg_out          (awg_out),
        .trigger_mode     (trigger_mode),
        .trig_in          (trig_in),
        .dac_data         (dac_data),
        .dac_strobe       (dac_strobe),
        .fifo_level       (fifo_level),
        .armed            (armed),
        .underrun_latched (underrun_latched)
    );

    always #5 clk100 = ~clk100;

    always @(posedge clk100) cyc <= cyc + 1;

    always @(negedge clk100) begin
        if (dac_strobe === 1'b1) begin
            sdata.push_back(dac_data);
            stime.push_back(cyc);
        end
    end

    task automatic apply_reset(input logic [6:0] mode);
        rst = 1'b1;
        awg_valid = 1'b0;
        trig_in = 1'b0;
        trigger_mode = mode;
        repeat (3) @(negedge clk100);
        rst = 1'b0;
        @(negedge clk100);
    endtask

    task automatic push(input logic [7:0] d);
        awg_valid = 1'b1;
        awg_out = d;
        @(negedge clk100);
        awg_valid = 1'b0;
    endtask

    task automatic pulse_trig;
        trig_in = 1'b1;
        repeat (3) @(negedge clk100);
        trig_in = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        trigger_mode = TRIGGER_MODE_NONE;
        repeat (2) @(negedge clk100);
        tests++; if (dac_data !== 8'h00) begin fails++; $display("FAIL reset_dac_data got %h exp 00", dac_data); end
        tests++; if (dac_strobe !== 1'b0) begin fails++; $display("FAIL reset_strobe got %b exp 0", dac_strobe); end
        tests++; if (fifo_level !== 5'd0) begin fails++; $display("FAIL reset_level got %0d exp 0", fifo_level); end
        tests++; if (armed !== 1'b0) begin fails++; $display("FAIL reset_armed got %b exp 0", armed); end
        tests++; if (underrun_latched !== 1'b0) begin fails++; $display("FAIL reset_underrun got %b exp 0", underrun_latched); end
        tests++; if (awg_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b exp 1", awg_ready); end
    endtask

    task automatic test_none_mode;
        int base;
        apply_reset(TRIGGER_MODE_NONE);
        base = sdata.size();
        push(8'h11); push(8'h22); push(8'h33);
        repeat (30) @(negedge clk100);
        tests++; if (sdata.size() - base !== 3) begin fails++; $display("FAIL none_strobe_count got %0d exp 3", sdata.size() - base); end
        if (sdata.size() - base >= 3) begin
            tests++; if (sdata[base] !== 8'h11) begin fails++; $display("FAIL none_data0 got %h exp 11", sdata[base]); end
            tests++; if (sdata[base+1] !== 8'h22) begin fails++; $display("FAIL none_data1 got %h exp 22", sdata[base+1]); end
            tests++; if (sdata[base+2] !== 8'h33) begin fails++; $display("FAIL none_data2 got %h exp 33", sdata[base+2]); end
            tests++; if (stime[base+1] - stime[base] !== 4) begin fails++; $display("FAIL none_gap01 got %0d exp 4", stime[base+1] - stime[base]); end
            tests++; if (stime[base+2] - stime[base+1] !== 4) begin fails++; $display("FAIL none_gap12 got %0d exp 4", stime[base+2] - stime[base+1]); end
        end
        tests++; if (underrun_latched !== 1'b1) begin fails++; $display("FAIL none_underrun got %b exp 1", underrun_latched); end
        tests++; if (armed !== 1'b0) begin fails++; $display("FAIL none_armed got %b exp 0", armed); end
    endtask

    task automatic test_edge_burst;
        int base;
        apply_reset(TRIGGER_MODE_EDGE);
        repeat (3) @(negedge clk100);
        base = sdata.size();
        for (int i = 0; i < 5; i++) push(8'(8'hA1 + i));
        repeat (20) @(negedge clk100);
        tests++; if (armed !== 1'b1) begin fails++; $display("FAIL edge_armed_pre got %b exp 1", armed); end
        tests++; if (sdata.size() - base !== 0) begin fails++; $display("FAIL edge_no_strobe got %0d exp 0", sdata.size() - base); end
        tests++; if (fifo_level !== 5'd5) begin fails++; $display("FAIL edge_level_pre got %0d exp 5", fifo_level); end
        pulse_trig();
        repeat (40) @(negedge clk100);
        tests++; if (sdata.size() - base !== 5) begin fails++; $display("FAIL edge_strobe_count got %0d exp 5", sdata.size() - base); end
        if (sdata.size() - base >= 5) begin
            for (int i = 0; i < 5; i++) begin
                tests++; if (sdata[base+i] !== 8'(8'hA1 + i)) begin fails++; $display("FAIL edge_data%0d got %h exp %h", i, sdata[base+i], 8'(8'hA1 + i)); end
            end
        end
        tests++; if (armed !== 1'b1) begin fails++; $display("FAIL edge_armed_post got %b exp 1", armed); end
        tests++; if (underrun_latched !== 1'b0) begin fails++; $display("FAIL edge_underrun got %b exp 0", underrun_latched); end
        tests++; if (fifo_level !== 5'd0) begin fails++; $display("FAIL edge_level_post got %0d exp 0", fifo_level); end
    endtask

    task automatic test_fill;
        int k;
        apply_reset(TRIGGER_MODE_EDGE);
        repeat (3) @(negedge clk100);
        for (int i = 0; i < 16; i++) push(8'(8'h40 + i));
        tests++; if (fifo_level !== 5'd16) begin fails++; $display("FAIL fill_level got %0d exp 16", fifo_level); end
        tests++; if (awg_ready !== 1'b0) begin fails++; $display("FAIL fill_ready got %b exp 0", awg_ready); end
        awg_valid = 1'b1;
        awg_out = 8'h99;
        repeat (5) @(negedge clk100);
        tests++; if (fifo_level !== 5'd16) begin fails++; $display("FAIL fill_held_off got %0d exp 16", fifo_level); end
        pulse_trig();
        k = 0;
        while (dac_strobe !== 1'b1 && k < 40) begin
            @(negedge clk100);
            k++;
        end
        awg_valid = 1'b0;
        tests++; if (k >= 40) begin fails++; $display("FAIL fill_first_strobe got timeout exp strobe"); end
        tests++; if (dac_data !== 8'h40) begin fails++; $display("FAIL fill_first_data got %h exp 40", dac_data); end
        tests++; if (fifo_level !== 5'd15) begin fails++; $display("FAIL fill_level_after_pop got %0d exp 15", fifo_level); end
        tests++; if (awg_ready !== 1'b1) begin fails++; $display("FAIL fill_ready_after_pop got %b exp 1", awg_ready); end
        repeat (3) @(negedge clk100);
        awg_valid = 1'b1;
        awg_out = 8'h99;
        @(negedge clk100);
        awg_valid = 1'b0;
        tests++; if (dac_strobe !== 1'b1) begin fails++; $display("FAIL fill_second_strobe got %b exp 1", dac_strobe); end
        tests++; if (dac_data !== 8'h41) begin fails++; $display("FAIL fill_second_data got %h exp 41", dac_data); end
        tests++; if (fifo_level !== 5'd15) begin fails++; $display("FAIL fill_push_pop_level got %0d exp 15", fifo_level); end
    endtask

    task automatic test_reset_edge;
        int base;
        apply_reset(TRIGGER_MODE_EDGE);
        repeat (3) @(negedge clk100);
        push(8'h5A);
        pulse_trig();
        repeat (20) @(negedge clk100);
        tests++; if (dac_data !== 8'h5A) begin fails++; $display("FAIL redge_setup_data got %h exp 5a", dac_data); end
        tests++; if (armed !== 1'b1) begin fails++; $display("FAIL redge_setup_armed got %b exp 1", armed); end
        base = sdata.size();
        for (int i = 0; i < 7; i++) push(8'(8'h60 + i));
        trigger_mode = RESET_EDGE;
        repeat (4) @(negedge clk100);
        tests++; if (fifo_level !== 5'd7) begin fails++; $display("FAIL redge_mode_change_level got %0d exp 7", fifo_level); end
        tests++; if (dac_data !== 8'h5A) begin fails++; $display("FAIL redge_mode_change_data got %h exp 5a", dac_data); end
        tests++; if (armed !== 1'b1) begin fails++; $display("FAIL redge_armed_pre got %b exp 1", armed); end
        pulse_trig();
        repeat (6) @(negedge clk100);
        tests++; if (fifo_level !== 5'd0) begin fails++; $display("FAIL redge_flush_level got %0d exp 0", fifo_level); end
        tests++; if (armed !== 1'b1) begin fails++; $display("FAIL redge_armed_post got %b exp 1", armed); end
        tests++; if (dac_data !== 8'h5A) begin fails++; $display("FAIL redge_data_held got %h exp 5a", dac_data); end
        tests++; if (sdata.size() - base !== 0) begin fails++; $display("FAIL redge_no_strobe got %0d exp 0", sdata.size() - base); end
        tests++; if (awg_ready !== 1'b1) begin fails++; $display("FAIL redge_ready got %b exp 1", awg_ready); end
    endtask

    task automatic test_reset_mid_burst;
        int k;
        apply_reset(TRIGGER_MODE_EDGE);
        repeat (3) @(negedge clk100);
        for (int i = 0; i < 5; i++) push(8'(8'h70 + i));
        pulse_trig();
        k = 0;
        while (dac_strobe !== 1'b1 && k < 40) begin
            @(negedge clk100);
            k++;
        end
        tests++; if (k >= 40) begin fails++; $display("FAIL mid_first_strobe got timeout exp strobe"); end
        @(negedge clk100);
        rst = 1'b1;
        #1;
        tests++; if (dac_strobe !== 1'b0) begin fails++; $display("FAIL mid_rst_strobe got %b exp 0", dac_strobe); end
        tests++; if (dac_data !== 8'h00) begin fails++; $display("FAIL mid_rst_data got %h exp 00", dac_data); end
        tests++; if (fifo_level !== 5'd0) begin fails++; $display("FAIL mid_rst_level got %0d exp 0", fifo_level); end
        tests++; if (armed !== 1'b0) begin fails++; $display("FAIL mid_rst_armed got %b exp 0", armed); end
        tests++; if (underrun_latched !== 1'b0) begin fails++; $display("FAIL mid_rst_underrun got %b exp 0", underrun_latched); end
        repeat (2) @(negedge clk100);
        rst = 1'b0;
        @(negedge clk100);
        push(8'h81);
        tests++; if (fifo_level !== 5'd1) begin fails++; $display("FAIL mid_post_push_level got %0d exp 1", fifo_level); end
        repeat (5) @(negedge clk100);
        tests++; if (armed !== 1'b1) begin fails++; $display("FAIL mid_post_armed got %b exp 1", armed); end
    endtask

    task automatic test_invalid_mode;
        int base;
        apply_reset(7'h55);
        base = sdata.size();
        push(8'h01); push(8'h02); push(8'h03);
        repeat (20) @(negedge clk100);
        tests++; if (armed !== 1'b0) begin fails++; $display("FAIL invalid_armed got %b exp 0", armed); end
        tests++; if (underrun_latched !== 1'b1) begin fails++; $display("FAIL invalid_underrun got %b exp 1", underrun_latched); end
        tests++; if (sdata.size() - base !== 0) begin fails++; $display("FAIL invalid_no_strobe got %0d exp 0", sdata.size() - base); end
        tests++; if (fifo_level !== 5'd3) begin fails++; $display("FAIL invalid_level got %0d exp 3", fifo_level); end
    endtask

    initial begin
        test_reset();
        test_none_mode();
        test_edge_burst();
        test_fill();
        test_reset_edge();
        test_reset_mid_burst();
        test_invalid_mode();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
